alarm_countdown_timer: RTL and testbench

Parametrised countdown timer for the alarm-clock datapath. It generalises the fixed down-from counter with:
- runtime load value and prescaled decrement rate
- start/stop/pause control
- one-shot or auto-reload mode
- borrow pulse for cascading stages, plus a sticky alarm flag cleared by acknowledge
Sits between the time-base divider and the alarm/display logic; instances cascade by feeding one stage's borrow into the next stage's start or a tick enable.

---
 rtl/alarm_countdown_timer.sv | 146 ++++++++++++++
 tb/tb_alarm_countdown_timer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_countdown_timer.sv
// Countdown timer stage: prescaled decrement, pause/resume, one-shot or auto-reload,
// borrow pulse for cascading stages and a sticky alarm flag cleared by ack.
module alarm_countdown_timer #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned PRESCALE     = 4,
   parameter int unsigned PS_WIDTH     = 3,
   parameter int unsigned DEFAULT_LOAD = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             reload_mode,
   input  logic             ack,
   output logic [WIDTH-1:0] count_out,
   output logic             borrow,
   output logic             alarm,
   output logic             busy,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRun     = 2'd1,
      StPause   = 2'd2,
      StExpired = 2'd3
   } state_e;

   localparam logic [WIDTH-1:0]    DefLoad = WIDTH'(DEFAULT_LOAD);
   localparam logic [WIDTH-1:0]    One     = WIDTH'(1);
   localparam logic [PS_WIDTH-1:0] PsLast  = PS_WIDTH'(PRESCALE - 1);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    count_q, count_d;
   logic [WIDTH-1:0]    reload_q, reload_d;
   logic [PS_WIDTH-1:0] ps_q, ps_d;
   logic                alarm_q, alarm_d;
   logic                borrow_q, borrow_d;
   logic                run_step;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      ps_d     = ps_q;
      alarm_d  = alarm_q;
      borrow_d = 1'b0;
      run_step = 1'b0;

      if (ack) begin
         alarm_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (load) begin
               count_d  = load_val;
               reload_d = load_val;
               ps_d     = '0;
            end else if (start && (count_q != '0)) begin
               state_d = StRun;
               ps_d    = '0;
            end
         end
         StRun: begin
            // A load while running only rearms the reload value; counting carries on.
            if (load) begin
               reload_d = load_val;
               run_step = 1'b1;
            end else if (stop) begin
               state_d = StPause;
            end else begin
               run_step = 1'b1;
            end
         end
         StPause: begin
            if (load) begin
               count_d  = load_val;
               reload_d = load_val;
               ps_d     = '0;
            end else if (start) begin
               state_d  = StRun;
               run_step = 1'b1;
            end
         end
         StExpired: begin
            if (load) begin
               count_d  = load_val;
               reload_d = load_val;
               ps_d     = '0;
               state_d  = StIdle;
            end else if (ack) begin
               count_d = reload_q;
               state_d = StIdle;
            end
         end
      endcase

      if (run_step) begin
         if (ps_q == PsLast) begin
            ps_d = '0;
            if (count_q > One) begin
               count_d = count_q - One;
            end else if (count_q == One) begin
               borrow_d = 1'b1;
               alarm_d  = 1'b1;
               if (reload_mode && (reload_q != '0)) begin
                  count_d = reload_q;
               end else begin
                  count_d = '0;
                  state_d = StExpired;
               end
            end
         end else begin
            ps_d = ps_q + PS_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         count_q  <= DefLoad;
         reload_q <= DefLoad;
         ps_q     <= '0;
         alarm_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         ps_q     <= ps_d;
         alarm_q  <= alarm_d;
         borrow_q <= borrow_d;
      end
   end

   assign count_out = count_q;
   assign borrow    = borrow_q;
   assign alarm     = alarm_q;
   assign state     = state_q;
   assign busy      = (state_q == StRun) || (state_q == StPause);

endmodule

// File: tb/tb_alarm_countdown_timer.sv
// Bench for alarm_countdown_timer: directed scenarios plus random stimulus, all checked
// against a behavioural model of the timer kept in plain integers.
module tb_alarm_countdown_timer;

   localparam int W    = 4;
   localparam int PS   = 2;
   localparam int DEFL = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         reload_mode = 1'b0;
   logic         ack = 1'b0;
   logic [W-1:0] count_out;
   logic         borrow;
   logic         alarm;
   logic         busy;
   logic [1:0]   state;

   int n_total = 0;
   int n_pass  = 0;

   // Model: spec state numbers 0..3, edges-run counter for the prescaler.
   int m_count  = DEFL;
   int m_reload = DEFL;
   int m_phase  = 0;
   int m_st     = 0;
   int m_alarm  = 0;
   int m_borrow = 0;

   alarm_countdown_timer #(
      .WIDTH(W),
      .PRESCALE(PS),
      .PS_WIDTH(1),
      .DEFAULT_LOAD(DEFL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .load(load),
      .load_val(load_val),
      .start(start),
      .stop(stop),
      .reload_mode(reload_mode),
      .ack(ack),
      .count_out(count_out),
      .borrow(borrow),
      .alarm(alarm),
      .busy(busy),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   // One edge of the timer, from the rules as written.
   task automatic model_edge();
      int  prev_reload;
      bit  counting;
      prev_reload = m_reload;
      counting    = 0;
      m_borrow    = 0;
      if (!rst) begin
         m_count = DEFL; m_reload = DEFL; m_phase = 0; m_st = 0; m_alarm = 0;
         return;
      end
      if (ack) m_alarm = 0;
      case (m_st)
         0: if (load) begin
               m_count = load_val; m_reload = load_val; m_phase = 0;
            end else if (start && m_count != 0) begin
               m_st = 1; m_phase = 0;
            end
         1: if (load) begin
               m_reload = load_val; counting = 1;
            end else if (stop) m_st = 2;
            else counting = 1;
         2: if (load) begin
               m_count = load_val; m_reload = load_val; m_phase = 0;
            end else if (start) begin
               m_st = 1; counting = 1;
            end
         default: if (load) begin
               m_count = load_val; m_reload = load_val; m_phase = 0; m_st = 0;
            end else if (ack) begin
               m_count = m_reload; m_st = 0;
            end
      endcase
      if (counting) begin
         m_phase = (m_phase + 1) % PS;
         if (m_phase == 0) begin
            if (m_count > 1) m_count = m_count - 1;
            else if (m_count == 1) begin
               m_borrow = 1; m_alarm = 1;
               if (reload_mode && prev_reload != 0) m_count = prev_reload;
               else begin
                  m_count = 0; m_st = 3;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      check("count", 32'(count_out), 32'(m_count));
      check("state", 32'(state), 32'(m_st));
      check("alarm", 32'(alarm), 32'(m_alarm));
      check("borrow", 32'(borrow), 32'(m_borrow));
      check("busy", 32'(busy), 32'((m_st == 1) || (m_st == 2)));
   endtask

   task automatic step(input logic ld, input logic [W-1:0] lv, input logic st, input logic sp,
                       input logic rm, input logic ak);
      load = ld; load_val = lv; start = st; stop = sp; reload_mode = rm; ack = ak;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n, input logic rm);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, rm, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle(1, 1'b0);
      rst = 1'b1;
   endtask

   initial begin
      logic rm_r;

      // One-shot countdown from the reset value
      do_reset();
      check("rst_count", 32'(count_out), 32'd3);
      check("rst_state", 32'(state), 32'd0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);        // N
      idle(2, 1'b0);
      check("os_n2", 32'(count_out), 32'd2);
      idle(2, 1'b0);
      check("os_n4", 32'(count_out), 32'd1);
      idle(2, 1'b0);
      check("os_n6_cnt", 32'(count_out), 32'd0);
      check("os_n6_borrow", 32'(borrow), 32'd1);
      check("os_n6_state", 32'(state), 32'd3);
      check("os_n6_busy", 32'(busy), 32'd0);
      idle(1, 1'b0);
      check("os_n7_borrow", 32'(borrow), 32'd0);
      check("os_n7_alarm", 32'(alarm), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("os_ack_state", 32'(state), 32'd0);
      check("os_ack_count", 32'(count_out), 32'd3);
      check("os_ack_alarm", 32'(alarm), 32'd0);

      // Auto-reload
      do_reset();
      step(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);        // N
      idle(4, 1'b1);
      check("rl_n4_borrow", 32'(borrow), 32'd1);
      check("rl_n4_count", 32'(count_out), 32'd2);
      idle(4, 1'b1);
      check("rl_n8_borrow", 32'(borrow), 32'd1);
      check("rl_n8_state", 32'(state), 32'd1);
      check("rl_n8_alarm", 32'(alarm), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("rl_ack_alarm", 32'(alarm), 32'd0);
      check("rl_ack_state", 32'(state), 32'd1);

      // Pause and resume with held prescaler
      do_reset();
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);        // N
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);        // N+1
      idle(9, 1'b0);
      check("pz_count", 32'(count_out), 32'd3);
      check("pz_state", 32'(state), 32'd2);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);        // N+11
      idle(1, 1'b0);
      check("pz_n12_count", 32'(count_out), 32'd2);

      // Stop on a tick edge
      do_reset();
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("stk_count", 32'(count_out), 32'd3);
      check("stk_borrow", 32'(borrow), 32'd0);
      check("stk_state", 32'(state), 32'd2);

      // Start ignored with zero count
      do_reset();
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("zero_state", 32'(state), 32'd0);

      // Load while running only rearms reload
      do_reset();
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);        // N
      step(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);      // N+1
      check("ldrun_count", 32'(count_out), 32'd3);
      idle(5, 1'b1);
      check("ldrun_borrow", 32'(borrow), 32'd1);
      check("ldrun_reload", 32'(count_out), 32'd9);

      // Synchronous reset mid-run, asserted between edges
      do_reset();
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("srst_hold_count", 32'(count_out), 32'd1);
      check("srst_hold_state", 32'(state), 32'd1);
      idle(1, 1'b0);
      check("srst_count", 32'(count_out), 32'd3);
      check("srst_state", 32'(state), 32'd0);
      rst = 1'b1;

      // Random traffic against the model
      rm_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(49) == 0) rm_r = ~rm_r;
         rst = ($urandom_range(63) != 0);
         step($urandom_range(15) == 0, W'($urandom_range(15)), $urandom_range(5) == 0,
              $urandom_range(11) == 0, rm_r, $urandom_range(9) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
